// File: rtl/text_pkg.sv
// Shared constants, state encoding and byte classification for the UART text writer.
package text_pkg;

   localparam int COLS = 32;
   localparam int ROWS = 4;

   localparam logic [7:0] BLANK = 8'h20;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] BS    = 8'h08;
   localparam logic [7:0] DEL   = 8'h7F;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      EXEC,
      ECHO
   } state_t;

   typedef enum logic [1:0] {
      PRINT,
      NEWLINE,
      BACKSPACE,
      OTHER
   } byte_class_t;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_HOME,
      OP_ADVANCE,
      OP_NEWLINE,
      OP_RETREAT
   } cursor_op_t;

   function automatic byte_class_t classify(input logic [7:0] b);
      byte_class_t c;
      if (b >= 8'h20 && b <= 8'h7E)
         c = PRINT;
      else if (b == CR || b == LF)
         c = NEWLINE;
      else if (b == BS || b == DEL)
         c = BACKSPACE;
      else
         c = OTHER;
      return c;
   endfunction

endpackage

// File: rtl/cursor_pos.sv
// Cursor row/column registers; rows and columns wrap naturally as both are powers of two.
module cursor_pos #(
   parameter int COLS = 32,
   parameter int ROWS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  text_pkg::cursor_op_t       op,
   output logic [$clog2(ROWS)-1:0]    row,
   output logic [$clog2(COLS)-1:0]    col
);
   import text_pkg::*;

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);

   always_ff @(posedge clk) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else begin
         case (op)
            OP_HOME: begin
               row <= '0;
               col <= '0;
            end
            OP_ADVANCE: begin
               if (col == COL_W'(COLS - 1)) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
            end
            OP_NEWLINE: begin
               col <= '0;
               row <= row + ROW_W'(1);
            end
            // Backspace never crosses into the previous row
            OP_RETREAT: begin
               if (col != '0)
                  col <= col - COL_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_text_writer.sv
// Sequential controller turning received UART bytes into character-RAM writes,
// cursor movement, screen clears and transmitter echoes.
module uart_text_writer #(
   parameter int         COLS    = text_pkg::COLS,
   parameter int         ROWS    = text_pkg::ROWS,
   parameter int         ECHO_EN = 1,
   parameter logic [7:0] BLANK   = text_pkg::BLANK
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   input  logic                       clear_req,
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   output logic                       wr_en,
   output logic [$clog2(ROWS)-1:0]    wr_row,
   output logic [$clog2(COLS)-1:0]    wr_col,
   output logic [7:0]                 wr_data,
   output logic [$clog2(ROWS)-1:0]    cur_row,
   output logic [$clog2(COLS)-1:0]    cur_col,
   output logic                       busy,
   output logic [7:0]                 drop_cnt
);
   import text_pkg::*;

   localparam int COL_W = $clog2(COLS);
   localparam int IDX_W = $clog2(ROWS * COLS);

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  clr_idx;
   logic [7:0]        byte_q;
   logic              last_was_cr;
   byte_class_t       cls;
   logic              handled;
   logic              lf_after_cr;
   logic              clr_last;
   logic              tx_fire;
   cursor_op_t        cur_op;

   cursor_pos #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk   (clk),
      .reset (reset),
      .op    (cur_op),
      .row   (cur_row),
      .col   (cur_col)
   );

   assign cls         = classify(byte_q);
   assign handled     = (cls != OTHER);
   assign lf_after_cr = (byte_q == LF) && last_was_cr;
   assign clr_last    = (clr_idx == IDX_W'(ROWS * COLS - 1));
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset)
         state <= CLEAR;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR: if (clr_last) state_next = IDLE;
         IDLE: begin
            if (clear_req)
               state_next = CLEAR;
            else if (rx_valid)
               state_next = EXEC;
         end
         EXEC: begin
            if (clear_req)
               state_next = CLEAR;
            else if (ECHO_EN != 0 && handled)
               state_next = ECHO;
            else
               state_next = IDLE;
         end
         ECHO: begin
            if (clear_req)
               state_next = CLEAR;
            else if (!tx_busy)
               state_next = IDLE;
         end
         default: state_next = CLEAR;
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_row  = clr_idx[IDX_W-1:COL_W];
      wr_col  = clr_idx[COL_W-1:0];
      wr_data = BLANK;
      cur_op  = OP_NONE;
      tx_fire = 1'b0;
      case (state)
         CLEAR: begin
            wr_en = 1'b1;
            if (clr_last)
               cur_op = OP_HOME;
         end
         EXEC: begin
            case (cls)
               PRINT: begin
                  wr_en   = 1'b1;
                  wr_row  = cur_row;
                  wr_col  = cur_col;
                  wr_data = byte_q;
                  cur_op  = OP_ADVANCE;
               end
               // LF straight after CR is swallowed so CRLF advances one line
               NEWLINE: begin
                  if (!lf_after_cr)
                     cur_op = OP_NEWLINE;
               end
               BACKSPACE: begin
                  if (cur_col != '0) begin
                     wr_en   = 1'b1;
                     wr_row  = cur_row;
                     wr_col  = cur_col - COL_W'(1);
                     wr_data = BLANK;
                     cur_op  = OP_RETREAT;
                  end
               end
               default: begin
               end
            endcase
         end
         ECHO: tx_fire = !tx_busy && !clear_req;
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clr_idx     <= '0;
         last_was_cr <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         drop_cnt    <= 8'h00;
      end else begin
         tx_start <= tx_fire;
         if (tx_fire)
            tx_data <= byte_q;

         if (state == CLEAR)
            clr_idx <= clr_idx + IDX_W'(1);
         else if (state_next == CLEAR)
            clr_idx <= '0;

         if (state == EXEC)
            last_was_cr <= (byte_q == CR);

         // No input buffering: anything arriving while not ready to accept is lost
         if (rx_valid && (state != IDLE || clear_req) && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && rx_valid && !clear_req)
         byte_q <= rx_data;
   end

endmodule

// File: tb/tb_uart_text_writer.sv
// Randomised self-checking bench for uart_text_writer with a screen/cursor reference model.
module tb_uart_text_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       clear_req = 1'b0;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       wr_en;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_data;
   logic [1:0] cur_row;
   logic [4:0] cur_col;
   logic       busy;
   logic [7:0] drop_cnt;

   uart_text_writer dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .clear_req (clear_req),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a flat 128-cell screen with a linear cursor position
   logic [7:0] m_ram [128];
   int         m_row = 0;
   int         m_col = 0;
   bit         m_last_cr = 0;
   int         m_drop = 0;

   // Observed activity
   int         wr_cnt = 0;
   int         tx_cnt = 0;
   logic [7:0] shadow [128];
   logic [6:0] last_w_addr = '0;
   logic [7:0] last_w_data = '0;
   logic [7:0] last_tx = '0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         last_w_addr = {wr_row, wr_col};
         last_w_data = wr_data;
         shadow[{wr_row, wr_col}] = wr_data;
      end
      if (tx_start === 1'b1) begin
         tx_cnt++;
         last_tx = tx_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
      m_row = 0;
      m_col = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit w, output int idx,
                             output logic [7:0] d, output bit echo);
      int pos;
      w = 0; idx = 0; d = 8'h20; echo = 1;
      if (b >= 8'h20 && b <= 8'h7E) begin
         w = 1; idx = m_row * 32 + m_col; d = b;
         pos = (idx + 1) % 128;
         m_row = pos / 32;
         m_col = pos % 32;
      end else if (b == 8'h0D || (b == 8'h0A && !m_last_cr)) begin
         m_row = (m_row + 1) % 4;
         m_col = 0;
      end else if (b == 8'h0A) begin
         pos = 0;
      end else if (b == 8'h08 || b == 8'h7F) begin
         if (m_col > 0) begin
            m_col = m_col - 1;
            w = 1; idx = m_row * 32 + m_col; d = 8'h20;
         end
      end else begin
         echo = 0;
      end
      if (w) m_ram[idx] = d;
      m_last_cr = (b == 8'h0D);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", tag, busy, n);
      end
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w0, t0, e_idx;
      bit e_w, e_echo;
      logic [7:0] e_d;
      wait_idle(300, "pre_send");
      w0 = wr_cnt;
      t0 = tx_cnt;
      model_byte(b, e_w, e_idx, e_d, e_echo);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      wait_idle(300, "post_send");
      checks++;
      if (wr_cnt - w0 !== int'(e_w)) begin
         errors++;
         $display("FAIL write_count byte=%h: got %0d expected %0d", b, wr_cnt - w0, e_w);
      end
      if (e_w) begin
         checks++;
         if (last_w_addr !== 7'(e_idx) || last_w_data !== e_d) begin
            errors++;
            $display("FAIL write_target byte=%h: got addr %0d data %h expected addr %0d data %h",
                     b, last_w_addr, last_w_data, e_idx, e_d);
         end
      end
      checks++;
      if (tx_cnt - t0 !== int'(e_echo) || (e_echo && last_tx !== b)) begin
         errors++;
         $display("FAIL echo byte=%h: got %0d starts data %h expected %0d starts data %h",
                  b, tx_cnt - t0, last_tx, e_echo, b);
      end
      checks++;
      if (cur_row !== 2'(m_row) || cur_col !== 5'(m_col)) begin
         errors++;
         $display("FAIL cursor byte=%h: got (%0d,%0d) expected (%0d,%0d)",
                  b, cur_row, cur_col, m_row, m_col);
      end
   endtask

   task automatic check_cursor(input string tag, input int r, input int c);
      checks++;
      if (cur_row !== 2'(r) || cur_col !== 5'(c)) begin
         errors++;
         $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", tag, cur_row, cur_col, r, c);
      end
   endtask

   function automatic logic [7:0] rand_print();
      return 8'($urandom_range(32, 126));
   endfunction

   task automatic test_reset();
      int n = 0;
      int bad = 0;
      int bad_i = -1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || drop_cnt !== 8'h00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: got tx_start=%b tx_data=%h drop=%0d busy=%b expected 0 00 0 1",
                  tx_start, tx_data, drop_cnt, busy);
      end
      check_cursor("reset_cursor", 0, 0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 130; i++) begin
         if (wr_en === 1'b1) begin
            if ({wr_row, wr_col} !== 7'(n) || wr_data !== 8'h20) begin
               bad++;
               if (bad_i < 0) bad_i = n;
            end
            n++;
         end
         @(negedge clk);
      end
      checks++;
      if (n !== 128) begin
         errors++;
         $display("FAIL clear_pulses: got %0d expected 128", n);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL clear_sequence: got %0d bad writes (first at %0d) expected 0", bad, bad_i);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_done_busy: got %b expected 0", busy);
      end
      check_cursor("clear_done_cursor", 0, 0);
      model_clear();
      m_last_cr = 0;
      m_drop = 0;
   endtask

   task automatic test_single_a();
      send_byte(8'h41);
      check_cursor("after_A", 0, 1);
   endtask

   task automatic test_wrap();
      repeat (3) send_byte(8'h0A);
      check_cursor("wrap_start", 3, 0);
      for (int i = 0; i < 32; i++) send_byte(rand_print());
      checks++;
      if (last_w_addr !== {2'd3, 5'd31}) begin
         errors++;
         $display("FAIL wrap_last_write: got addr %0d expected %0d", last_w_addr, 127);
      end
      check_cursor("wrap_end", 0, 0);
   endtask

   task automatic test_crlf();
      int w0;
      send_byte(8'h0A);
      repeat (5) send_byte(rand_print());
      check_cursor("crlf_start", 1, 5);
      w0 = wr_cnt;
      send_byte(8'h0D);
      send_byte(8'h0A);
      check_cursor("crlf_end", 2, 0);
      checks++;
      if (wr_cnt !== w0) begin
         errors++;
         $display("FAIL crlf_writes: got %0d expected 0", wr_cnt - w0);
      end
      send_byte(8'h0A);
      check_cursor("lone_lf", 3, 0);
   endtask

   task automatic test_backspace();
      repeat (3) send_byte(8'h0A);
      repeat (3) send_byte(rand_print());
      check_cursor("bs_start", 2, 3);
      send_byte(8'h08);
      checks++;
      if (last_w_addr !== {2'd2, 5'd2} || last_w_data !== 8'h20) begin
         errors++;
         $display("FAIL bs_write: got addr %0d data %h expected addr 66 data 20", last_w_addr, last_w_data);
      end
      check_cursor("bs_cursor", 2, 2);
      send_byte(8'h7F);
      send_byte(8'h08);
      send_byte(8'h08);
      check_cursor("bs_col0", 2, 0);
   endtask

   task automatic test_random();
      int r, bad;
      logic [7:0] b;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: b = 8'h0D;
            1: b = 8'h0A;
            2: b = 8'h08;
            3: b = 8'h7F;
            4: b = 8'($urandom_range(0, 31));
            5: b = 8'($urandom_range(128, 255));
            default: b = rand_print();
         endcase
         send_byte(b);
      end
      bad = 0;
      for (int i = 0; i < 128; i++) if (shadow[i] !== m_ram[i]) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL screen_contents: got %0d differing cells expected 0", bad);
      end
   endtask

   task automatic test_drop_and_clear();
      int w0, t0, bad, e_idx;
      bit e_w, e_echo;
      logic [7:0] e_d;
      wait_idle(300, "pre_drop");
      tx_busy = 1'b1;
      t0 = tx_cnt;
      model_byte(8'h78, e_w, e_idx, e_d, e_echo);
      rx_data = 8'h78;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         rx_data = rand_print();
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         @(negedge clk);
      end
      m_drop += 3;
      repeat (38) @(negedge clk);
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin
         errors++;
         $display("FAIL drop_count: got %0d expected %0d", drop_cnt, m_drop);
      end
      checks++;
      if (busy !== 1'b1 || tx_cnt !== t0) begin
         errors++;
         $display("FAIL echo_held: got busy=%b starts=%0d expected busy=1 starts=0", busy, tx_cnt - t0);
      end
      w0 = wr_cnt;
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (20) @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      wait_idle(400, "clear_from_echo");
      tx_busy = 1'b0;
      repeat (5) @(negedge clk);
      model_clear();
      checks++;
      if (wr_cnt - w0 !== 128) begin
         errors++;
         $display("FAIL clear_from_echo_writes: got %0d expected 128", wr_cnt - w0);
      end
      checks++;
      if (tx_cnt !== t0) begin
         errors++;
         $display("FAIL abandoned_echo: got %0d starts expected 0", tx_cnt - t0);
      end
      check_cursor("clear_from_echo_cursor", 0, 0);
      bad = 0;
      for (int i = 0; i < 128; i++) if (shadow[i] !== 8'h20) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL cleared_screen: got %0d non-blank cells expected 0", bad);
      end
   endtask

   task automatic test_clear_vs_rx();
      int w0, t0;
      wait_idle(300, "pre_clear_rx");
      w0 = wr_cnt;
      t0 = tx_cnt;
      clear_req = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h41;
      @(negedge clk);
      clear_req = 1'b0;
      rx_valid = 1'b0;
      m_drop += 1;
      wait_idle(400, "clear_vs_rx");
      checks++;
      if (drop_cnt !== 8'(m_drop) || wr_cnt - w0 !== 128 || tx_cnt !== t0) begin
         errors++;
         $display("FAIL clear_beats_rx: got drop=%0d writes=%0d starts=%0d expected drop=%0d writes=128 starts=0",
                  drop_cnt, wr_cnt - w0, tx_cnt - t0, m_drop);
      end
      check_cursor("clear_beats_rx_cursor", 0, 0);
      for (int round = 0; round < 3; round++) begin
         clear_req = 1'b1;
         @(negedge clk);
         clear_req = 1'b0;
         rx_valid = 1'b1;
         rx_data = rand_print();
         repeat (100) @(negedge clk);
         rx_valid = 1'b0;
         m_drop = (m_drop + 100 > 255) ? 255 : m_drop + 100;
         wait_idle(400, "drop_round");
         checks++;
         if (drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL drop_saturate round %0d: got %0d expected %0d", round, drop_cnt, m_drop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_wrap();
      test_crlf();
      test_backspace();
      test_random();
      test_drop_and_clear();
      test_clear_vs_rx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_text_writer.md
Name: uart_text_writer

Overview:
- Sits between the UART receiver and the 4x32 character RAM write port.
- Turns each received byte into cursor movement and RAM writes: printable characters, CR/LF, and backspace.
- Clears the screen on reset or on request, and echoes accepted bytes back to the UART transmitter.
- Replaces ad-hoc cursor logic in the top level with a single sequential controller.

Parameters:
- COLS, 32, characters per row (power of 2); column width = log2(COLS).
- ROWS, 4, text rows (power of 2); row width = log2(ROWS).
- ECHO_EN, 1, when 1, accepted bytes are echoed via the tx handshake.
- BLANK, 8'h20, fill character for clear and backspace.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte, valid with rx_valid.
- rx_valid  in  1  single-cycle strobe (already single-pulsed).
- clear_req  in  1  single-cycle strobe: clear screen and home the cursor.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  single-cycle echo request.
- tx_data  out  8  echo byte; held from tx_start until the next accepted byte.
- wr_en  out  1  RAM write enable.
- wr_row  out  2  RAM write row.
- wr_col  out  5  RAM write column.
- wr_data  out  8  RAM write data.
- cur_row  out  2  cursor row (for 7-seg and display).
- cur_col  out  5  cursor column.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  8  count of bytes lost while busy; saturates at 255.

Behaviour:
- States: CLEAR, IDLE, EXEC, ECHO.
- Reset:
  - Enters CLEAR with clear index 0, cursor (0,0).
  - tx_start=0, tx_data=0, drop_cnt=0, last_was_cr=0.
  - Reset asserted mid-operation restarts CLEAR from index 0.
- CLEAR:
  - Runs 128 cycles (ROWS*COLS); busy=1 throughout.
  - Each cycle: wr_en=1, wr_data=BLANK, {wr_row,wr_col} = index in row-major order.
  - After index 127: cursor (0,0), go to IDLE.
  - clear_req during CLEAR is ignored.
- IDLE:
  - clear_req goes to CLEAR; it beats rx_valid in the same cycle, and that byte is counted as dropped.
  - Otherwise, rx_valid latches the byte and goes to EXEC.
- EXEC is one cycle; the byte latched on cycle N is processed on cycle N+1:
  - Printable (0x20..0x7E): wr_en=1, write at the cursor, then advance the column.
    - At col COLS-1: col wraps to 0 and row+1; row wraps ROWS-1 to 0. No scrolling.
  - CR (0x0D): col=0, row+1 (wrapping); no write.
  - LF (0x0A): col=0, row+1 (wrapping); no write.
    - An LF arriving as the next accepted byte after a CR is a no-op, so CRLF moves one line only.
  - BS (0x08) or DEL (0x7F):
    - If col>0: col-1, and write BLANK at the new position in the same cycle.
    - If col=0: no-op; the cursor never moves to the previous row.
  - Any other byte: ignored, not echoed.
  - last_was_cr is updated for every accepted byte.
  - cur_row/cur_col show the new cursor value from cycle N+2.
  - Next state: ECHO if ECHO_EN and the byte was handled; otherwise IDLE.
- ECHO:
  - Waits while tx_busy=1.
  - On the first cycle with tx_busy=0: tx_start=1 for exactly one cycle, tx_data=byte, then IDLE.
  - clear_req in EXEC/ECHO abandons the echo and goes to CLEAR.
- rx_valid in any state other than IDLE: byte dropped, drop_cnt+1 (saturating); there is no input buffering.
- wr_en is never high outside CLEAR/EXEC, and never for more than one cycle per byte.

Decomposition:
- Package text_pkg holds:
  - COLS, ROWS, BLANK.
  - ASCII constants: CR, LF, BS, DEL.
  - State encoding.
  - Classification function returning PRINT/NEWLINE/BACKSPACE/OTHER.
- Natural sub-module: cursor_pos, holding the row/col registers with ops home/advance/newline/retreat and wrap logic.
- The FSM, clear index, echo handshake, and drop counter stay in uart_text_writer.

Test Plan:
- Reset, run 130 cycles: exactly 128 wr_en pulses, addresses 0..127 row-major, data 0x20. Then busy=0, cursor (0,0).
- Send 'A' (0x41) in IDLE: wr_en one cycle at (0,0) data 0x41; cursor (0,1); tx_start with tx_data 0x41 once tx_busy=0.
- Send 32 printable bytes from (3,0): last write at (3,31); cursor wraps to (0,0).
- Send 0x0D then 0x0A from (1,5): cursor (2,0), no writes. Then a standalone 0x0A: cursor (3,0).
- BS at (2,3): write 0x20 at (2,2), cursor (2,2). BS at (2,0): no write, cursor unchanged, echo still issued.
- Hold tx_busy=1 for 50 cycles after a byte, send 3 more rx_valid strobes: drop_cnt=3. Assert clear_req in ECHO: no tx_start, CLEAR runs 128 writes.
